uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Serialiser between the downstream FIFO (DFIFO) and the UART TX pin. Pops bytes from a show-ahead
//  DFIFO and emits start / data / optional parity / stop bits, timed by UART_BIT_LENGTH. It applies
//  CTRL fields and drives the tx_status flag plus the IRQ_TX_STARTED / IRQ_TX_DONE event pulses.
// PARAMETERS
//  DATA_WIDTH     8   frame data bits; equals DFIFO_WIDTH
//  BIT_LEN_WIDTH  32  width of bit-length and baud counters
// PORTS
//  clk_i              in   1              single clock
//  rstn_i             in   1              asynchronous active-low reset
//  fifo_data_i        in   DATA_WIDTH     DFIFO head word; valid while !fifo_empty_i
//  fifo_empty_i       in   1              DFIFO empty
//  fifo_rd_o          out  1              DFIFO pop strobe, one cycle
//  bit_length_i       in   BIT_LEN_WIDTH  clocks per bit (UART_BIT_LENGTH)
//  stop_bit_mode_i    in   2              HALF/FULL/ONE_AND_HALF/TWO_PERIODS
//  msb_first_i        in   1              1: data MSB first
//  send_parity_i      in   1              1: append even parity bit
//  hw_flow_ctrl_en_i  in   1              1: frame start gated by CTS
//  cts_n_i            in   1              clear-to-send, active-low, asynchronous
//  tx_o               out  1              serial line, idle high
//  tx_busy_o          out  1              STATS.tx_status; 1 = not IDLE
//  tx_started_o       out  1              IRQ_TX_STARTED pulse
//  tx_done_o          out  1              IRQ_TX_DONE pulse
// BEHAVIOUR
//  Reset: tx_o=1; fifo_rd_o, tx_busy_o, tx_started_o, tx_done_o = 0; FSM=IDLE; counters cleared.
//   Reset mid-frame: line returns high asynchronously; latched byte discarded; nothing re-popped.
//  FSM: IDLE -> START -> DATA -> [PARITY if send_parity] -> STOP -> IDLE.
//  IDLE: if !fifo_empty_i && (!hw_flow_ctrl_en_i || cts_sync==0):
//   pulse fifo_rd_o; latch fifo_data_i and all config inputs; go START next cycle.
//  cts_n_i passes a 2-flop synchroniser and only gates frame start. A CTS deassert mid-frame
//   does not stop the frame in progress.
//  Config and bit_length are sampled only at pop. Changes mid-frame take effect on the next frame.
//  L = latched bit_length; L==0 is treated as 1. START, each DATA bit and PARITY last L cycles.
//  STOP lasts S cycles: HALF=max(1,L>>1), FULL=L, ONE_AND_HALF=L+(L>>1), TWO=2L.
//   Widths: L+(L>>1) and 2L are computed in BIT_LEN_WIDTH+1 bits with no overflow.
//  tx_o: START=0; DATA=latched bit (LSB first, or MSB first when msb_first); PARITY=^data (even);
//   STOP/IDLE=1. tx_o is registered.
//  Timing: pop in cycle T; tx_o falls and tx_started_o pulses in T+1.
//   tx_done_o pulses in the first IDLE cycle after STOP, T+1+L*(1+DATA_WIDTH+p)+S.
//  Back-to-back: at least one IDLE cycle between frames; the next pop may occur in the tx_done_o cycle.
//  tx_busy_o = 1 from T+1 through the last STOP cycle.
// CONFIGURATION
//  Macro UART_TX_BREAK_EN adds input break_i (1 bit). When break_i=1 in IDLE, tx_o is driven 0
//   and no pop occurs. A break request made mid-frame waits until after tx_done_o. The line
//   releases to 1 the cycle after break_i falls. tx_busy_o=1 during break; no IRQ pulses.
//  Without the macro, break_i does not exist and the line idles at 1.
// TESTING
//  L=4, FULL, LSB first, no parity, push 0xA5 -> tx_o 0,1,0,1,0,0,1,0,1,1 at 4 clk/bit;
//   tx_done_o 40 cycles after tx_started_o.
//  send_parity=1, push 0x07 -> parity bit 1; push 0x03 -> parity bit 0; frame is 44 cycles.
//  msb_first=1, push 0x80 -> first data bit 1, remaining 7 bits 0.
//  L=4 and modes HALF/FULL/ONE_AND_HALF/TWO -> stop high for 2/4/6/8 cycles; L=0 -> 1 clk/bit.
//  hw_flow_ctrl_en=1, cts_n=1 with FIFO non-empty -> no pop; drop cts_n -> fifo_rd_o within 3 cycles;
//   raise cts_n mid-frame -> frame completes.
//  Assert rstn_i low mid-DATA -> tx_o=1 immediately, all outputs 0; after release, next pop only when
//   FIFO non-empty. With UART_TX_BREAK_EN: break_i=1 in IDLE holds tx_o=0 and leaves the FIFO untouched.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// DFIFO read-side handshake between a show-ahead FIFO (master) and the UART TX engine (slave).
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_empty_i;
  logic                  fifo_rd_o;

  modport master (output fifo_data_i, output fifo_empty_i, input fifo_rd_o);
  modport slave  (input fifo_data_i, input fifo_empty_i, output fifo_rd_o);
endinterface

// File: rtl/uart_tx_engine.sv
// UART TX serialiser: pops a show-ahead DFIFO and emits start/data/[parity]/stop bits.
// Optional line-break support is enabled by defining UART_TX_BREAK_EN.
module uart_tx_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int BIT_LEN_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  uart_tx_engine_if.slave          fifo_if,
  input  logic [BIT_LEN_WIDTH-1:0] bit_length_i,
  input  logic [1:0]               stop_bit_mode_i,
  input  logic                     msb_first_i,
  input  logic                     send_parity_i,
  input  logic                     hw_flow_ctrl_en_i,
  input  logic                     cts_n_i,
`ifdef UART_TX_BREAK_EN
  input  logic                     break_i,
`endif
  output logic                     tx_o,
  output logic                     tx_busy_o,
  output logic                     tx_started_o,
  output logic                     tx_done_o
);

  localparam int CW = BIT_LEN_WIDTH + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  typedef enum logic [1:0] {STOP_HALF, STOP_FULL, STOP_ONE_HALF, STOP_TWO} stop_mode_t;

  state_t                   r_state, w_state_n;
  logic [CW-1:0]            r_cnt, w_cnt_n;
  logic [IW-1:0]            r_idx, w_idx_n;
  logic [BIT_LEN_WIDTH-1:0] r_len;
  logic [CW-1:0]            r_stop;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_msb, r_par;
  logic                     r_cts_meta, r_cts_sync;
  logic                     r_tx, r_busy, r_started, r_done;
  logic                     w_tx_n, w_busy_n, w_started_n, w_done_n;
  logic [BIT_LEN_WIDTH-1:0] w_len, w_half;
  logic [CW-1:0]            w_stop, w_len_m1;
  logic                     w_pop, w_break, w_last;

`ifdef UART_TX_BREAK_EN
  assign w_break = break_i;
`else
  assign w_break = 1'b0;
`endif

  assign w_len  = (bit_length_i == '0) ? BIT_LEN_WIDTH'(1) : bit_length_i;
  assign w_half = w_len >> 1;

  // Stop length is fixed at pop time, in one extra bit so 1.5L and 2L cannot overflow.
  always_comb begin
    w_stop = CW'(w_len);
    case (stop_mode_t'(stop_bit_mode_i))
      STOP_HALF:     w_stop = (w_half == '0) ? CW'(1) : CW'(w_half);
      STOP_FULL:     w_stop = CW'(w_len);
      STOP_ONE_HALF: w_stop = CW'(w_len) + CW'(w_half);
      STOP_TWO:      w_stop = {w_len, 1'b0};
      default:       w_stop = CW'(w_len);
    endcase
  end

  assign w_pop = rstn_i && (r_state == ST_IDLE) && !w_break && !fifo_if.fifo_empty_i &&
                 (!hw_flow_ctrl_en_i || !r_cts_sync);
  assign fifo_if.fifo_rd_o = w_pop;

  assign w_last   = (r_cnt == '0);
  assign w_len_m1 = CW'(r_len) - CW'(1);

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_idx_n     = r_idx;
    w_started_n = 1'b0;
    w_done_n    = 1'b0;
    if (r_state != ST_IDLE && !w_last) w_cnt_n = r_cnt - CW'(1);
    case (r_state)
      ST_IDLE: if (w_pop) begin
        w_state_n   = ST_START;
        w_cnt_n     = CW'(w_len) - CW'(1);
        w_started_n = 1'b1;
      end
      ST_START: if (w_last) begin
        w_state_n = ST_DATA;
        w_cnt_n   = w_len_m1;
        w_idx_n   = '0;
      end
      ST_DATA: if (w_last) begin
        if (r_idx == IW'(DATA_WIDTH - 1)) begin
          w_state_n = r_par ? ST_PARITY : ST_STOP;
          w_cnt_n   = r_par ? w_len_m1 : r_stop - CW'(1);
        end else begin
          w_idx_n = r_idx + IW'(1);
          w_cnt_n = w_len_m1;
        end
      end
      ST_PARITY: if (w_last) begin
        w_state_n = ST_STOP;
        w_cnt_n   = r_stop - CW'(1);
      end
      ST_STOP: if (w_last) begin
        w_state_n = ST_IDLE;
        w_done_n  = 1'b1;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // The line level is computed for the state being entered so tx_o is a clean register.
  always_comb begin
    w_tx_n = 1'b1;
    case (w_state_n)
      ST_START:  w_tx_n = 1'b0;
      ST_DATA:   w_tx_n = r_msb ? r_data[IW'(DATA_WIDTH - 1) - w_idx_n] : r_data[w_idx_n];
      ST_PARITY: w_tx_n = ^r_data;
      default:   w_tx_n = (r_state == ST_IDLE) ? !w_break : 1'b1;
    endcase
    w_busy_n = (w_state_n != ST_IDLE) || ((r_state == ST_IDLE) && w_break);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_len      <= '0;
      r_stop     <= '0;
      r_data     <= '0;
      r_msb      <= 1'b0;
      r_par      <= 1'b0;
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_started  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cts_meta <= cts_n_i;
      r_cts_sync <= r_cts_meta;
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_tx       <= w_tx_n;
      r_busy     <= w_busy_n;
      r_started  <= w_started_n;
      r_done     <= w_done_n;
      if (w_pop) begin
        r_data <= fifo_if.fifo_data_i;
        r_len  <= w_len;
        r_stop <= w_stop;
        r_msb  <= msb_first_i;
        r_par  <= send_parity_i;
      end
    end
  end

  assign tx_o         = r_tx;
  assign tx_busy_o    = r_busy;
  assign tx_started_o = r_started;
  assign tx_done_o    = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: frame table, randomized frames vs a bit-list model,
// and hand sequences for back-to-back, CTS gating and mid-frame reset.
module tb_uart_tx_engine;
  localparam int DW  = 8;
  localparam int BLW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_engine_if #(.DATA_WIDTH(DW)) fif();

  logic [BLW-1:0] bit_length = '0;
  logic [1:0]     stop_mode = 2'd1;
  logic           msb_first = 1'b0, send_parity = 1'b0, hwfc = 1'b0, cts_n = 1'b1, brk = 1'b0;
  logic           tx, busy, started, done;

  uart_tx_engine #(.DATA_WIDTH(DW), .BIT_LEN_WIDTH(BLW)) dut (
    .clk_i(clk), .rstn_i(rstn), .fifo_if(fif),
    .bit_length_i(bit_length), .stop_bit_mode_i(stop_mode), .msb_first_i(msb_first),
    .send_parity_i(send_parity), .hw_flow_ctrl_en_i(hwfc), .cts_n_i(cts_n),
`ifdef UART_TX_BREAK_EN
    .break_i(brk),
`endif
    .tx_o(tx), .tx_busy_o(busy), .tx_started_o(started), .tx_done_o(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: list of line levels per cycle from start bit through the last stop cycle.
  logic exp_q[$];
  task automatic build_model(input logic [7:0] d, input int L, input logic [1:0] m,
                             input bit msb, input bit par);
    int l, s;
    logic b;
    l = (L == 0) ? 1 : L;
    case (m)
      2'd0:    s = (l / 2 < 1) ? 1 : l / 2;
      2'd1:    s = l;
      2'd2:    s = l + l / 2;
      default: s = 2 * l;
    endcase
    exp_q.delete();
    repeat (l) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b = msb ? d[7 - i] : d[i];
      repeat (l) exp_q.push_back(b);
    end
    if (par) begin
      b = ($countones(d) % 2) == 1;
      repeat (l) exp_q.push_back(b);
    end
    repeat (s) exp_q.push_back(1'b1);
  endtask

  logic act_q[$];
  int   act_done_at;
  bit   act_started_ok, act_busy_ok;

  task automatic wait_pop(input int budget, output int cycles);
    cycles = -1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (fif.fifo_rd_o === 1'b1) begin
        cycles = t;
        break;
      end
    end
  endtask

  task automatic collect_frame(input int budget, input bit raise_cts_mid);
    act_q.delete();
    act_done_at = -1;
    act_started_ok = 1'b1;
    act_busy_ok = 1'b1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (raise_cts_mid && t == 5) cts_n = 1'b1;
      if ((t == 0) != (started === 1'b1)) act_started_ok = 1'b0;
      if (done === 1'b1) begin
        act_done_at = t;
        if (busy !== 1'b0) act_busy_ok = 1'b0;
        break;
      end
      act_q.push_back(tx);
      if (busy !== 1'b1) act_busy_ok = 1'b0;
    end
  endtask

  function automatic int wave_diff();
    int n = 0;
    if (act_q.size() != exp_q.size()) n++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic check_frame(input string name);
    check({name, "_started"}, act_started_ok, 1);
    check({name, "_len"}, act_done_at, exp_q.size());
    check({name, "_wave"}, wave_diff(), 0);
    check({name, "_busy"}, act_busy_ok, 1);
  endtask

  task automatic present(input logic [7:0] d, input int L, input logic [1:0] m,
                         input bit msb, input bit par);
    fif.fifo_data_i = d;
    fif.fifo_empty_i = 1'b0;
    bit_length = BLW'(L);
    stop_mode = m;
    msb_first = msb;
    send_parity = par;
  endtask

  // One frame with config scrambled right after the pop to show it was latched.
  task automatic do_frame(input string name, input logic [7:0] d, input int L,
                          input logic [1:0] m, input bit msb, input bit par);
    int c;
    @(posedge clk); #1;
    present(d, L, m, msb, par);
    wait_pop(10, c);
    check({name, "_pop"}, c, 0);
    @(posedge clk); #1;
    fif.fifo_empty_i = 1'b1;
    fif.fifo_data_i = ~d;
    bit_length = BLW'($urandom_range(1, 9));
    stop_mode = 2'($urandom);
    msb_first = ~msb;
    send_parity = ~par;
    build_model(d, L, m, msb, par);
    collect_frame(300, 1'b0);
    check_frame(name);
  endtask

  typedef struct {
    logic [7:0] d;
    int         L;
    logic [1:0] m;
    bit         msb;
    bit         par;
    int         exp_len;
    int         exp_stop;
    int         exp_first;
    int         exp_par;
  } vec_t;

  vec_t vt[$];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int c, l, k, ones, done_at, pop2_at;
    fif.fifo_data_i = '0;
    fif.fifo_empty_i = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_started", started, 0);
    check("rst_done", done, 0);
    check("rst_rd", fif.fifo_rd_o, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    //        d      L  mode  msb par len stop first par
    vt.push_back('{8'hA5, 4, 2'd1, 0, 0, 40, 4, 1, -1});
    vt.push_back('{8'h07, 4, 2'd1, 0, 1, 44, 4, 1,  1});
    vt.push_back('{8'h03, 4, 2'd1, 0, 1, 44, 4, 1,  0});
    vt.push_back('{8'h80, 4, 2'd1, 1, 0, 40, 4, 1, -1});
    vt.push_back('{8'h5A, 4, 2'd0, 0, 0, 38, 2, 0, -1});
    vt.push_back('{8'h5A, 4, 2'd2, 0, 0, 42, 6, 0, -1});
    vt.push_back('{8'h5A, 4, 2'd3, 0, 0, 44, 8, 0, -1});
    vt.push_back('{8'hC3, 0, 2'd1, 0, 0, 10, 1, 1, -1});
    vt.push_back('{8'hC3, 1, 2'd0, 0, 0, 10, 1, 1, -1});
    vt.push_back('{8'h3C, 3, 2'd2, 1, 1, 34, 4, 0,  0});

    for (int v = 0; v < vt.size(); v++) begin
      do_frame($sformatf("vec%0d", v), vt[v].d, vt[v].L, vt[v].m, vt[v].msb, vt[v].par);
      l = (vt[v].L == 0) ? 1 : vt[v].L;
      check($sformatf("vec%0d_tab_len", v), act_done_at, vt[v].exp_len);
      check($sformatf("vec%0d_first", v), (act_q.size() > l) ? act_q[l] : 1'bx, vt[v].exp_first);
      if (vt[v].exp_par >= 0)
        check($sformatf("vec%0d_parity", v), (act_q.size() > 9 * l) ? act_q[9 * l] : 1'bx,
              vt[v].exp_par);
      k = (vt[v].par ? 10 : 9) * l;
      ones = 0;
      for (int i = k; i < act_q.size(); i++) if (act_q[i] === 1'b1) ones++;
      check($sformatf("vec%0d_stop", v), ones, vt[v].exp_stop);
    end

    for (int r = 0; r < 24; r++)
      do_frame($sformatf("rnd%0d", r), 8'($urandom), int'($urandom_range(0, 6)),
               2'($urandom), 1'($urandom), 1'($urandom));

    // Back-to-back: second pop lands in the tx_done_o cycle.
    @(posedge clk); #1;
    present(8'h69, 2, 2'd1, 0, 1);
    wait_pop(10, c);
    check("b2b_pop1", c, 0);
    @(posedge clk); #1;
    fif.fifo_data_i = 8'h96;
    done_at = -1;
    pop2_at = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done === 1'b1 && done_at < 0) done_at = t;
      if (fif.fifo_rd_o === 1'b1) begin
        pop2_at = t;
        break;
      end
    end
    check("b2b_done_at", done_at, 2 * 10 + 2);
    check("b2b_pop2_at", pop2_at, 2 * 10 + 2);
    @(posedge clk); #1;
    fif.fifo_empty_i = 1'b1;
    build_model(8'h96, 2, 2'd1, 0, 1);
    collect_frame(300, 1'b0);
    check_frame("b2b_second");

    // CTS gating: held off while cts_n=1; deassert mid-frame does not abort.
    @(posedge clk); #1;
    hwfc = 1'b1;
    cts_n = 1'b1;
    present(8'h3C, 2, 2'd1, 0, 1);
    wait_pop(12, c);
    check("cts_hold", c, -1);
    cts_n = 1'b0;
    wait_pop(3, c);
    check("cts_go", (c >= 0 && c <= 2) ? 1 : 0, 1);
    @(posedge clk); #1;
    fif.fifo_empty_i = 1'b1;
    build_model(8'h3C, 2, 2'd1, 0, 1);
    collect_frame(300, 1'b1);
    check_frame("cts_frame");
    hwfc = 1'b0;

    // Reset mid-DATA with a zero byte so the line is low when reset hits.
    @(posedge clk); #1;
    present(8'h00, 4, 2'd1, 0, 0);
    wait_pop(10, c);
    check("rstmid_pop", c, 0);
    repeat (10) @(negedge clk);
    check("rstmid_pre_tx", tx, 0);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_started", started, 0);
    check("rstmid_done", done, 0);
    check("rstmid_rd", fif.fifo_rd_o, 0);
    fif.fifo_empty_i = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_pop(6, c);
    check("rstmid_no_pop", c, -1);
    do_frame("post_rst", 8'hB4, 3, 2'd3, 1, 1);

`ifdef UART_TX_BREAK_EN
    @(posedge clk); #1;
    brk = 1'b1;
    present(8'h55, 2, 2'd1, 0, 0);
    wait_pop(8, c);
    check("brk_no_pop", c, -1);
    check("brk_tx", tx, 0);
    check("brk_busy", busy, 1);
    fif.fifo_empty_i = 1'b1;
    brk = 1'b0;
    @(negedge clk);
    check("brk_release", tx, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
